maze_walker: RTL and testbench

- Parametrised wall-follower maze solver.
- Walks a square grid of 2^ADDR_W x 2^ADDR_W cells using a synchronous one-bit cell memory: maze_in=1 means wall, 0 means free.
- Follows the right-hand or left-hand rule, selected by parameter, and marks every visited cell through maze_we.
- Adds a start handshake, step counting, step-limit timeout and enclosed-start detection.

---
 rtl/maze_walker_if.sv | 13 +
 rtl/maze_walker.sv | 183 ++++++++++++++++++
 tb/tb_maze_walker.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_walker_if.sv
// Cell-memory port of the maze walker: cell address, read/mark strobes and read data.
interface maze_walker_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic              maze_oe;
  logic              maze_we;
  logic              maze_in;

  modport master (output row, col, maze_oe, maze_we, input maze_in);
  modport slave  (input row, col, maze_oe, maze_we, output maze_in);
endinterface

// File: rtl/maze_walker.sv
// Wall-following maze solver over a synchronous one-bit cell memory.
// Marks every visited cell, counts moves and aborts on step limit or an enclosed start.
module maze_walker #(
  parameter int ADDR_W    = 6,
  parameter int HAND      = 0,
  parameter int STEP_W    = 16,
  parameter int MAX_STEPS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] starting_row,
  input  logic [ADDR_W-1:0] starting_col,
  input  logic [1:0]        start_dir,
  maze_walker_if.master     mem,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [STEP_W-1:0] step_count
);

  typedef enum logic [3:0] {
    IDLE, START, PROBE_SIDE, CHECK_SIDE, PROBE_FWD, CHECK_FWD, STEP, DONE, FAIL
  } state_t;

  localparam logic [ADDR_W-1:0] MAXI       = '1;
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);
  localparam logic [1:0]        SIDE_INC   = (HAND == 0) ? 2'd1 : 2'd3;

  state_t            state;
  logic [ADDR_W-1:0] pos_row;
  logic [ADDR_W-1:0] pos_col;
  logic [1:0]        heading;
  logic [2:0]        turn_cnt;
  logic              off_grid_q;

  logic [1:0]        side_dir;
  logic [1:0]        away_dir;
  logic [1:0]        probe_dir;
  logic [1:0]        move_dir;
  logic [ADDR_W-1:0] probe_row;
  logic [ADDR_W-1:0] probe_col;
  logic [ADDR_W-1:0] move_row;
  logic [ADDR_W-1:0] move_col;
  logic              probe_off;
  logic              cell_free;
  logic              at_border;

  function automatic logic [ADDR_W-1:0] next_row(input logic [ADDR_W-1:0] r, input logic [1:0] d);
    if (d == 2'd0) return r - ONE;
    else if (d == 2'd2) return r + ONE;
    else return r;
  endfunction

  function automatic logic [ADDR_W-1:0] next_col(input logic [ADDR_W-1:0] c, input logic [1:0] d);
    if (d == 2'd1) return c + ONE;
    else if (d == 2'd3) return c - ONE;
    else return c;
  endfunction

  function automatic logic leaves_grid(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] c,
                                       input logic [1:0] d);
    return (d == 2'd0 && r == '0) || (d == 2'd1 && c == MAXI) ||
           (d == 2'd2 && r == MAXI) || (d == 2'd3 && c == '0);
  endfunction

  assign side_dir  = heading + SIDE_INC;
  assign away_dir  = heading - SIDE_INC;
  assign move_dir  = (state == CHECK_SIDE) ? side_dir : heading;
  assign move_row  = next_row(pos_row, move_dir);
  assign move_col  = next_col(pos_col, move_dir);
  assign probe_row = next_row(pos_row, probe_dir);
  assign probe_col = next_col(pos_col, probe_dir);
  assign probe_off = leaves_grid(pos_row, pos_col, probe_dir);
  assign cell_free = !off_grid_q && !mem.maze_in;
  assign at_border = (pos_row == '0) || (pos_row == MAXI) || (pos_col == '0) || (pos_col == MAXI);

  // The probe issued on leaving a state depends on which state is being left.
  always_comb begin
    probe_dir = side_dir;
    if (state == CHECK_SIDE) probe_dir = heading;
    else if (state == CHECK_FWD) probe_dir = away_dir;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pos_row     <= '0;
      pos_col     <= '0;
      heading     <= 2'd0;
      turn_cnt    <= 3'd0;
      off_grid_q  <= 1'b0;
      mem.row     <= '0;
      mem.col     <= '0;
      mem.maze_oe <= 1'b0;
      mem.maze_we <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      step_count  <= '0;
    end else begin
      mem.maze_oe <= 1'b0;
      mem.maze_we <= 1'b0;
      unique case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            state       <= START;
            pos_row     <= starting_row;
            pos_col     <= starting_col;
            heading     <= start_dir;
            turn_cnt    <= 3'd0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            step_count  <= '0;
            busy        <= 1'b1;
            mem.row     <= starting_row;
            mem.col     <= starting_col;
            mem.maze_we <= 1'b1;
          end
        end
        START: begin
          state       <= PROBE_SIDE;
          off_grid_q  <= probe_off;
          mem.row     <= probe_off ? pos_row : probe_row;
          mem.col     <= probe_off ? pos_col : probe_col;
          mem.maze_oe <= !probe_off;
        end
        PROBE_SIDE: state <= CHECK_SIDE;
        PROBE_FWD:  state <= CHECK_FWD;
        CHECK_SIDE, CHECK_FWD: begin
          if (cell_free) begin
            // Entering STEP: the move, its mark and the count all land together.
            state       <= STEP;
            heading     <= move_dir;
            pos_row     <= move_row;
            pos_col     <= move_col;
            mem.row     <= move_row;
            mem.col     <= move_col;
            mem.maze_we <= 1'b1;
            turn_cnt    <= 3'd0;
            if (step_count != STEP_LIMIT) step_count <= step_count + STEP_W'(1);
          end else if (state == CHECK_FWD && turn_cnt == 3'd3) begin
            state    <= FAIL;
            heading  <= away_dir;
            turn_cnt <= turn_cnt + 3'd1;
            timeout  <= 1'b1;
            busy     <= 1'b0;
          end else begin
            state       <= PROBE_FWD;
            off_grid_q  <= probe_off;
            mem.row     <= probe_off ? pos_row : probe_row;
            mem.col     <= probe_off ? pos_col : probe_col;
            mem.maze_oe <= !probe_off;
            if (state == CHECK_FWD) begin
              heading  <= away_dir;
              turn_cnt <= turn_cnt + 3'd1;
            end
          end
        end
        STEP: begin
          if (at_border) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (step_count == STEP_LIMIT) begin
            state   <= FAIL;
            timeout <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state       <= PROBE_SIDE;
            off_grid_q  <= probe_off;
            mem.row     <= probe_off ? pos_row : probe_row;
            mem.col     <= probe_off ? pos_col : probe_col;
            mem.maze_oe <= !probe_off;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_walker.sv
// Bench for maze_walker on an 8x8 grid: a walk-level reference model predicts every
// cycle of the memory bus and status outputs; directed mazes pin the model with literals.
module tb_maze_walker;

  localparam int AW   = 3;
  localparam int MAXI = 7;
  localparam int SW   = 16;

  typedef struct {
    bit rcv;
    int row;
    int col;
    bit oe;
    bit we;
    bit busy;
    bit done;
    bit tmo;
    int steps;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] starting_row = '0;
  logic [AW-1:0] starting_col = '0;
  logic [1:0]    start_dir = 2'd0;
  int            sel = 0;

  logic          busy_v [3];
  logic          done_v [3];
  logic          tmo_v [3];
  logic [SW-1:0] steps_v [3];

  logic [AW-1:0] obs_row, obs_col;
  logic          obs_oe, obs_we, obs_busy, obs_done, obs_tmo;
  logic [SW-1:0] obs_steps;

  bit   grid [8][8];
  int   dr [4] = '{-1, 0, 1, 0};
  int   dc [4] = '{0, 1, 0, -1};
  int   hand_of [3] = '{0, 1, 0};
  int   max_of [3] = '{100, 100, 6};

  exp_t exp_q [$];
  exp_t cur;
  bit   last_busy = 1'b0;
  int   we_cnt = 0;
  int   done_cycle = -1;
  int   vectors = 0;
  int   miscompares = 0;
  int   s_row, s_col, s_dir;

  maze_walker_if #(.ADDR_W(AW)) bus0 ();
  maze_walker_if #(.ADDR_W(AW)) bus1 ();
  maze_walker_if #(.ADDR_W(AW)) bus2 ();

  maze_walker #(.ADDR_W(AW), .HAND(0), .STEP_W(SW), .MAX_STEPS(100)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 0),
    .starting_row(starting_row), .starting_col(starting_col), .start_dir(start_dir),
    .mem(bus0), .busy(busy_v[0]), .done(done_v[0]), .timeout(tmo_v[0]), .step_count(steps_v[0]));

  maze_walker #(.ADDR_W(AW), .HAND(1), .STEP_W(SW), .MAX_STEPS(100)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 1),
    .starting_row(starting_row), .starting_col(starting_col), .start_dir(start_dir),
    .mem(bus1), .busy(busy_v[1]), .done(done_v[1]), .timeout(tmo_v[1]), .step_count(steps_v[1]));

  maze_walker #(.ADDR_W(AW), .HAND(0), .STEP_W(SW), .MAX_STEPS(6)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 2),
    .starting_row(starting_row), .starting_col(starting_col), .start_dir(start_dir),
    .mem(bus2), .busy(busy_v[2]), .done(done_v[2]), .timeout(tmo_v[2]), .step_count(steps_v[2]));

  always #5 clk = ~clk;

  // Cell memories: one-cycle read latency; unread cycles return noise.
  always @(posedge clk) begin
    if (bus0.maze_oe) bus0.maze_in <= grid[bus0.row][bus0.col];
    else bus0.maze_in <= 1'($urandom_range(0, 1));
    if (bus1.maze_oe) bus1.maze_in <= grid[bus1.row][bus1.col];
    else bus1.maze_in <= 1'($urandom_range(0, 1));
    if (bus2.maze_oe) bus2.maze_in <= grid[bus2.row][bus2.col];
    else bus2.maze_in <= 1'($urandom_range(0, 1));
  end

  always_comb begin
    obs_row = bus2.row; obs_col = bus2.col; obs_oe = bus2.maze_oe; obs_we = bus2.maze_we;
    obs_busy = busy_v[2]; obs_done = done_v[2]; obs_tmo = tmo_v[2]; obs_steps = steps_v[2];
    if (sel == 0) begin
      obs_row = bus0.row; obs_col = bus0.col; obs_oe = bus0.maze_oe; obs_we = bus0.maze_we;
      obs_busy = busy_v[0]; obs_done = done_v[0]; obs_tmo = tmo_v[0]; obs_steps = steps_v[0];
    end else if (sel == 1) begin
      obs_row = bus1.row; obs_col = bus1.col; obs_oe = bus1.maze_oe; obs_we = bus1.maze_we;
      obs_busy = busy_v[1]; obs_done = done_v[1]; obs_tmo = tmo_v[1]; obs_steps = steps_v[1];
    end
  end

  task automatic checkOutput(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic exp_push(input bit rcv, input int r, input int c, input bit oe, input bit we,
                          input bit busy, input bit dn, input bit tmo, input int steps);
    exp_t e;
    e.rcv = rcv; e.row = r; e.col = c; e.oe = oe; e.we = we;
    e.busy = busy; e.done = dn; e.tmo = tmo; e.steps = steps;
    exp_q.push_back(e);
  endtask

  // One look at a neighbour: an address cycle then a decision cycle.
  task automatic model_probe(input int r, input int c, input int dd, input int steps,
                             output bit free, output int nr, output int nc);
    bit off;
    nr  = r + dr[dd];
    nc  = c + dc[dd];
    off = (nr < 0) || (nr > MAXI) || (nc < 0) || (nc > MAXI);
    if (off) exp_push(1, r, c, 0, 0, 1, 0, 0, steps);
    else exp_push(1, nr, nc, 1, 0, 1, 0, 0, steps);
    exp_push(0, 0, 0, 0, 0, 1, 0, 0, steps);
    free = !off && !grid[nr][nc];
  endtask

  // Walks the maze with the hand rule and records what each cycle must show.
  task automatic build_model(input int hand, input int max_steps);
    int r, c, d, steps, nr, nc, turns, side_inc;
    bit free, fin;
    side_inc = (hand == 0) ? 1 : 3;
    r = s_row; c = s_col; d = s_dir; steps = 0; fin = 0;
    exp_q.delete();
    exp_push(1, r, c, 0, 1, 1, 0, 0, 0);
    while (!fin) begin
      model_probe(r, c, (d + side_inc) % 4, steps, free, nr, nc);
      if (free) d = (d + side_inc) % 4;
      else begin
        turns = 0;
        model_probe(r, c, d, steps, free, nr, nc);
        while (!free && turns < 4) begin
          d = (d + 4 - side_inc) % 4;
          turns++;
          if (turns < 4) model_probe(r, c, d, steps, free, nr, nc);
        end
      end
      if (!free) begin
        exp_push(0, 0, 0, 0, 0, 0, 0, 1, steps);
        exp_push(0, 0, 0, 0, 0, 0, 0, 1, steps);
        fin = 1;
      end else begin
        r = nr; c = nc; steps++;
        exp_push(1, r, c, 0, 1, 1, 0, 0, steps);
        if (r == 0 || r == MAXI || c == 0 || c == MAXI) begin
          exp_push(1, r, c, 0, 0, 0, 1, 0, steps);
          exp_push(1, r, c, 0, 0, 0, 1, 0, steps);
          fin = 1;
        end else if (steps == max_steps) begin
          exp_push(0, 0, 0, 0, 0, 0, 0, 1, steps);
          exp_push(0, 0, 0, 0, 0, 0, 0, 1, steps);
          fin = 1;
        end
      end
    end
  endtask

  // Per-cycle comparison of the selected walker against the model trace.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      vectors++;
      last_busy = cur.busy;
      if (obs_we === 1'b1) we_cnt++;
      if (obs_oe !== cur.oe || obs_we !== cur.we || obs_busy !== cur.busy ||
          obs_done !== cur.done || obs_tmo !== cur.tmo || int'(obs_steps) != cur.steps ||
          (cur.rcv && (int'(obs_row) != cur.row || int'(obs_col) != cur.col))) begin
        miscompares++;
        $display("[TB] FAIL trace t=%0t: got row=%0d col=%0d oe=%0b we=%0b busy=%0b done=%0b to=%0b steps=%0d, expected row=%0d col=%0d oe=%0b we=%0b busy=%0b done=%0b to=%0b steps=%0d",
                 $time, obs_row, obs_col, obs_oe, obs_we, obs_busy, obs_done, obs_tmo, obs_steps,
                 cur.row, cur.col, cur.oe, cur.we, cur.busy, cur.done, cur.tmo, cur.steps);
      end
    end
  end

  task automatic applyStimulus(input int inst, input int sr, input int sc, input int sd);
    @(negedge clk);
    #1;
    sel          = inst;
    s_row        = sr;
    s_col        = sc;
    s_dir        = sd;
    starting_row = AW'(sr);
    starting_col = AW'(sc);
    start_dir    = 2'(sd);
    build_model(hand_of[inst], max_of[inst]);
    we_cnt       = 0;
    done_cycle   = -1;
    start        = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitRun(input bit noise);
    int cyc = 1;
    while (exp_q.size() > 0 && cyc < 3000) begin
      if (noise && last_busy && $urandom_range(0, 7) == 0) begin
        start        = 1'b1;
        starting_row = AW'($urandom);
        starting_col = AW'($urandom);
        start_dir    = 2'($urandom);
      end
      @(negedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (obs_done && done_cycle < 0) done_cycle = cyc;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL walk_budget: got %0d trace entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic checkResult(input string tag, input int dn, input int tmo, input int r,
                             input int c, input int steps);
    checkOutput({tag, "_done"}, int'(obs_done), dn);
    checkOutput({tag, "_timeout"}, int'(obs_tmo), tmo);
    checkOutput({tag, "_steps"}, int'(obs_steps), steps);
    if (r >= 0) begin
      checkOutput({tag, "_row"}, int'(obs_row), r);
      checkOutput({tag, "_col"}, int'(obs_col), c);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_row"}, int'(obs_row), 0);
    checkOutput({tag, "_col"}, int'(obs_col), 0);
    checkOutput({tag, "_oe"}, int'(obs_oe), 0);
    checkOutput({tag, "_we"}, int'(obs_we), 0);
    checkOutput({tag, "_busy"}, int'(obs_busy), 0);
    checkOutput({tag, "_done"}, int'(obs_done), 0);
    checkOutput({tag, "_timeout"}, int'(obs_tmo), 0);
    checkOutput({tag, "_steps"}, int'(obs_steps), 0);
  endtask

  task automatic set_walls();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        grid[r][c] = 1'b1;
  endtask

  task automatic corridor_maze();
    set_walls();
    for (int c = 3; c <= 7; c++) grid[3][c] = 1'b0;
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    $display("[TB] straight corridor");
    corridor_maze();
    applyStimulus(0, 3, 3, 1);
    waitRun(0);
    checkResult("corridor", 1, 0, 3, 7, 4);
    checkOutput("corridor_done_cycle", done_cycle, 22);
    checkOutput("corridor_marks", we_cnt, 5);

    $display("[TB] right turn");
    set_walls();
    grid[3][3] = 0; grid[3][4] = 0; grid[4][4] = 0; grid[5][4] = 0; grid[6][4] = 0; grid[7][4] = 0;
    applyStimulus(0, 3, 3, 1);
    waitRun(0);
    checkResult("right_turn", 1, 0, 7, 4, 5);

    $display("[TB] left hand, mirrored maze");
    set_walls();
    grid[3][5] = 0; grid[3][4] = 0; grid[4][4] = 0; grid[5][4] = 0; grid[6][4] = 0; grid[7][4] = 0;
    applyStimulus(1, 3, 5, 3);
    waitRun(0);
    checkResult("left_hand", 1, 0, 7, 4, 5);

    $display("[TB] enclosed start");
    set_walls();
    grid[4][4] = 0;
    applyStimulus(0, 4, 4, 0);
    waitRun(0);
    checkResult("enclosed", 0, 1, -1, -1, 0);
    checkOutput("enclosed_marks", we_cnt, 1);

    $display("[TB] loop timeout");
    set_walls();
    grid[3][3] = 0; grid[3][4] = 0; grid[4][3] = 0; grid[4][4] = 0;
    applyStimulus(2, 3, 3, 1);
    waitRun(0);
    checkResult("loop", 0, 1, -1, -1, 6);

    $display("[TB] reset during a step");
    corridor_maze();
    applyStimulus(0, 3, 3, 1);
    cyc = 0;
    while (!(obs_we === 1'b1 && obs_steps == 16'd2) && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checkOutput("reset_reached_step", int'(obs_steps), 2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkAllZero("midwalk_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 3, 3, 1);
    waitRun(0);
    checkResult("after_reset", 1, 0, 3, 7, 4);
    checkOutput("after_reset_done_cycle", done_cycle, 22);
    checkOutput("after_reset_marks", we_cnt, 5);

    $display("[TB] random mazes");
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          grid[r][c] = ($urandom_range(0, 99) < 30);
      applyStimulus(i % 3, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)));
      waitRun(1);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
